// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared definitions for the multi-ported register file.
//   - addr_width(): address width for a given register count
//   - PC_IDX_DEFAULT: default architectural index of the program counter
//   - sb_cause_e: reason a scoreboard hazard pulse was raised
package reg_file_pkg;

  localparam int PC_IDX_DEFAULT = 15;

  typedef enum logic [1:0] {
    SB_NONE     = 2'd0,
    SB_DUP_LOAD = 2'd1,  // load issued to a register already awaiting a load
    SB_WAW_ALU  = 2'd2,  // ALU wrote a register still awaiting load data
    SB_STRAY_WB = 2'd3   // load writeback to a register with no load outstanding
  } sb_cause_e;

  // Never returns 0 so that a one-entry file still gets a legal address bus.
  function automatic int addr_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks registers with an outstanding load.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ld_issue, ld_rd   mark ld_rd as awaiting load data
//   wa_en, wa_addr    ALU write (checked only, never clears)
//   wb_en, wb_addr    load writeback (clears the pending bit)
//   pending           registered pending bit per register
//   sb_err            one-cycle registered hazard pulse
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int AW       = addr_width(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_issue,
  input  logic [AW-1:0]       ld_rd,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  output logic [NUM_REGS-1:0] pending,
  output logic                sb_err
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                sb_err_q, sb_err_d;
  sb_cause_e           cause;

  always_comb begin
    pending_d = pending_q;
    // Clear first, then set, so a new load to the register being written back wins.
    if (wb_en)    pending_d[wb_addr] = 1'b0;
    if (ld_issue) pending_d[ld_rd]   = 1'b1;

    cause = SB_NONE;
    if (wb_en && !pending_q[wb_addr])
      cause = SB_STRAY_WB;
    if (wa_en && pending_q[wa_addr])
      cause = SB_WAW_ALU;
    if (ld_issue && pending_q[ld_rd] && !(wb_en && (wb_addr == ld_rd)))
      cause = SB_DUP_LOAD;
    sb_err_d = (cause != SB_NONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign pending = pending_q;
  assign sb_err  = sb_err_q;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-ported register file with integrated PC and load scoreboard.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rd_addr / rd_data           NUM_RD combinational read ports (port i in slice i)
//   rd_pending                  read port's register has an outstanding load
//   wa_en / wa_addr / wa_data   write port A (ALU)
//   wb_en / wb_addr / wb_data   write port B (load writeback), wins over port A
//   ld_issue / ld_rd            load issued to ld_rd
//   pc_en                       advance PC by PC_STEP
//   pc_out                      current PC
//   sb_err                      one-cycle scoreboard hazard pulse
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 16,
  parameter int                NUM_RD   = 4,
  parameter int                PC_IDX   = PC_IDX_DEFAULT,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(4),
  parameter bit                BYPASS   = 1'b1,
  parameter int                AW       = addr_width(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wa_en,
  input  logic [AW-1:0]            wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     ld_issue,
  input  logic [AW-1:0]            ld_rd,
  input  logic                     pc_en,
  output logic [DATA_W-1:0]        pc_out,
  output logic                     sb_err
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending;

  // The PC lives in the ordinary register array; only its next-state rule differs.
  // Statement order gives the priority: port B, then port A, then pc_en, then hold.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      if ((r == PC_IDX) && pc_en)           regs_d[r] = regs_q[r] + PC_STEP;
      if (wa_en && (wa_addr == AW'(r)))     regs_d[r] = wa_data;
      if (wb_en && (wb_addr == AW'(r)))     regs_d[r] = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs_q[r] <= (r == PC_IDX) ? PC_RESET : '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        regs_q[r] <= regs_d[r];
    end
  end

  assign pc_out = regs_q[PC_IDX];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rd_addr[gi*AW +: AW];

      always_comb begin
        rd_data[gi*DATA_W +: DATA_W] = regs_q[ra];
        if (BYPASS) begin
          if (wb_en && (wb_addr == ra))
            rd_data[gi*DATA_W +: DATA_W] = wb_data;
          else if (wa_en && (wa_addr == ra))
            rd_data[gi*DATA_W +: DATA_W] = wa_data;
        end
      end

      assign rd_pending[gi] = pending[ra];
    end
  endgenerate

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_issue (ld_issue),
    .ld_rd    (ld_rd),
    .wa_en    (wa_en),
    .wa_addr  (wa_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .pending  (pending),
    .sb_err   (sb_err)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed + randomized checks of reg_file_mp against a
// behavioural model; expectations are queued by the driver and checked by a
// separate monitor on the falling edge.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int NP = 4;
  localparam int AW = 4;
  localparam int PCI = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP*AW-1:0]  rd_addr = '0;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_pending;
  logic              wa_en = 1'b0, wb_en = 1'b0, ld_issue = 1'b0, pc_en = 1'b0;
  logic [AW-1:0]     wa_addr = '0, wb_addr = '0, ld_rd = '0;
  logic [DW-1:0]     wa_data = '0, wb_data = '0;
  logic [DW-1:0]     pc_out;
  logic              sb_err;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .wa_en      (wa_en),
    .wa_addr    (wa_addr),
    .wa_data    (wa_data),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ld_issue   (ld_issue),
    .ld_rd      (ld_rd),
    .pc_en      (pc_en),
    .pc_out     (pc_out),
    .sb_err     (sb_err)
  );

  typedef struct {
    logic [NP*DW-1:0] rd_data;
    logic [NP-1:0]    rd_pending;
    logic [DW-1:0]    pc;
    logic             sb_err;
    string            tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: architectural view, PC kept apart from the GPRs.
  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_pc;
  bit            m_pend [NR];
  bit            m_err;

  function automatic logic [DW-1:0] m_read(input int a);
    if (wb_en && int'(wb_addr) == a) return wb_data;
    if (wa_en && int'(wa_addr) == a) return wa_data;
    if (a == PCI) return m_pc;
    return m_regs[a];
  endfunction

  function automatic exp_t m_expect(input string tag);
    exp_t e;
    for (int i = 0; i < NP; i++) begin
      int a;
      a = int'(rd_addr[i*AW +: AW]);
      e.rd_data[i*DW +: DW] = m_read(a);
      e.rd_pending[i]       = m_pend[a];
    end
    e.pc     = m_pc;
    e.sb_err = m_err;
    e.tag    = tag;
    return e;
  endfunction

  function automatic void m_reset();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
    m_pc  = '0;
    m_err = 1'b0;
  endfunction

  function automatic void m_edge();
    bit dup, waw, stray;
    dup   = ld_issue && m_pend[ld_rd] && !(wb_en && wb_addr == ld_rd);
    waw   = wa_en && m_pend[wa_addr];
    stray = wb_en && !m_pend[wb_addr];
    m_err = dup || waw || stray;
    if (wb_en && int'(wb_addr) == PCI)      m_pc = wb_data;
    else if (wa_en && int'(wa_addr) == PCI) m_pc = wa_data;
    else if (pc_en)                         m_pc = m_pc + 32'd4;
    if (wa_en && int'(wa_addr) != PCI) m_regs[wa_addr] = wa_data;
    if (wb_en && int'(wb_addr) != PCI) m_regs[wb_addr] = wb_data;
    if (wb_en)    m_pend[wb_addr] = 1'b0;
    if (ld_issue) m_pend[ld_rd]   = 1'b1;
  endfunction

  // Called just after a rising edge: drive one cycle of inputs, queue the
  // expected outputs for this cycle, then advance the model across the edge.
  task automatic apply(input string tag,
                       input logic wae, input logic [AW-1:0] waa, input logic [DW-1:0] wad,
                       input logic wbe, input logic [AW-1:0] wba, input logic [DW-1:0] wbd,
                       input logic ld, input logic [AW-1:0] ldr, input logic pce,
                       input logic [NP*AW-1:0] ra);
    wa_en = wae; wa_addr = waa; wa_data = wad;
    wb_en = wbe; wb_addr = wba; wb_data = wbd;
    ld_issue = ld; ld_rd = ldr; pc_en = pce; rd_addr = ra;
    exp_q.push_back(m_expect(tag));
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle(input string tag, input logic [NP*AW-1:0] ra);
    apply(tag, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, ra);
  endtask

  // Asserts reset between edges so its asynchronous effect is visible at the
  // next falling-edge check; released one cycle later.
  task automatic do_reset(input string tag, input logic [NP*AW-1:0] ra);
    wa_en = 1'b0; wb_en = 1'b0; ld_issue = 1'b0; pc_en = 1'b0; rd_addr = ra;
    rst_n = 1'b0;
    m_reset();
    exp_q.push_back(m_expect(tag));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int i = 0; i < NP; i++) begin
        n_vec++;
        if (rd_data[i*DW +: DW] !== e.rd_data[i*DW +: DW]) begin
          n_miss++;
          $display("FAIL %s rd_data[%0d]: got %h expected %h", e.tag, i,
                   rd_data[i*DW +: DW], e.rd_data[i*DW +: DW]);
        end
      end
      n_vec++;
      if (rd_pending !== e.rd_pending) begin
        n_miss++;
        $display("FAIL %s rd_pending: got %b expected %b", e.tag, rd_pending, e.rd_pending);
      end
      n_vec++;
      if (pc_out !== e.pc) begin
        n_miss++;
        $display("FAIL %s pc_out: got %h expected %h", e.tag, pc_out, e.pc);
      end
      n_vec++;
      if (sb_err !== e.sb_err) begin
        n_miss++;
        $display("FAIL %s sb_err: got %b expected %b", e.tag, sb_err, e.sb_err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NP*AW-1:0] ra4(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset", ra4(0, 1, 2, 15));

    // PC advance after reset, all registers read back zero
    apply("pc_adv0", 0, 0, 0, 0, 0, 0, 0, 0, 1, ra4(0, 1, 2, 3));
    apply("pc_adv1", 0, 0, 0, 0, 0, 0, 0, 0, 1, ra4(4, 5, 6, 7));
    apply("pc_adv2", 0, 0, 0, 0, 0, 0, 0, 0, 1, ra4(8, 9, 10, 11));
    idle("pc_12", ra4(12, 13, 14, 15));

    // Dual write to the same register: port B wins, bypassed same cycle
    apply("dual_wr", 1, 3, 32'h11, 1, 3, 32'h22, 0, 0, 0, ra4(3, 3, 0, 15));
    idle("dual_rd", ra4(3, 0, 3, 15));

    // ALU write to PC overrides pc_en
    apply("pc_wr", 1, 15, 32'h1000, 0, 0, 0, 0, 0, 1, ra4(15, 3, 0, 1));
    apply("pc_adv", 0, 0, 0, 0, 0, 0, 0, 0, 1, ra4(15, 3, 0, 1));
    idle("pc_1004", ra4(15, 3, 0, 1));

    // PC wrap
    apply("pc_set_top", 1, 15, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, ra4(15, 15, 0, 0));
    apply("pc_wrap", 0, 0, 0, 0, 0, 0, 0, 0, 1, ra4(15, 15, 0, 0));
    idle("pc_zero", ra4(15, 0, 0, 0));

    // Load scoreboard: issue, pending, writeback clears next cycle
    apply("ld_r5", 0, 0, 0, 0, 0, 0, 1, 5, 0, ra4(5, 0, 5, 1));
    idle("r5_pend", ra4(5, 0, 5, 1));
    apply("wb_r5", 0, 0, 0, 1, 5, 32'hABCD, 0, 0, 0, ra4(5, 0, 5, 1));
    idle("r5_clear", ra4(5, 0, 5, 1));

    // Hazards: duplicate load, stray writeback, ALU write to pending register
    apply("ld_r5_a", 0, 0, 0, 0, 0, 0, 1, 5, 0, ra4(5, 0, 0, 0));
    apply("ld_r5_dup", 0, 0, 0, 0, 0, 0, 1, 5, 0, ra4(5, 0, 0, 0));
    idle("dup_err", ra4(5, 7, 0, 0));
    apply("wb_r7_stray", 0, 0, 0, 1, 7, 32'h77, 0, 0, 0, ra4(7, 5, 0, 0));
    apply("wa_r5_waw", 1, 5, 32'h55, 0, 0, 0, 0, 0, 0, ra4(7, 5, 0, 0));
    idle("waw_err", ra4(7, 5, 0, 0));
    apply("ldwb_same", 0, 0, 0, 1, 5, 32'h5A5A, 1, 5, 0, ra4(5, 0, 0, 0));
    idle("set_wins", ra4(5, 0, 0, 0));
    idle("quiet", ra4(5, 0, 0, 0));

    // Reset while a load is outstanding
    apply("ld_r9", 0, 0, 0, 0, 0, 0, 1, 9, 1, ra4(9, 5, 15, 3));
    do_reset("rst_mid_load", ra4(9, 5, 15, 3));
    idle("post_rst", ra4(9, 5, 15, 3));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic wae, wbe, ld, pce;
      logic [AW-1:0] waa, wba, ldr;
      logic [DW-1:0] wad, wbd;
      wae = ($urandom_range(0, 2) == 0);
      wbe = ($urandom_range(0, 3) == 0);
      ld  = ($urandom_range(0, 3) == 0);
      pce = ($urandom_range(0, 1) == 1);
      waa = AW'($urandom_range(0, 15));
      wba = AW'($urandom_range(0, 15));
      ldr = AW'($urandom_range(0, 15));
      wad = $urandom;
      wbd = $urandom;
      apply("rand", wae, waa, wad, wbe, wba, wbd, ld, ldr, pce,
            ra4($urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 15)));
    end

    idle("final", ra4(0, 1, 2, 15));
    repeat (2) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Multi-ported, parametrised register file for the ARM core datapath: NUM_RD combinational read ports, two write ports (ALU result and load writeback), an internal program counter at register PC_IDX with auto-advance, and a load scoreboard that flags reads of registers awaiting load data. It sits between decode (read addresses), the ALU/shifter (port A writes), and the memory stage (port B writes). It replaces the single-write, reset-less register file.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 16, number of architectural registers; AW = $clog2(NUM_REGS)
- NUM_RD, 4, number of read ports (Rn, Rs, Rm, Rd order by convention)
- PC_IDX, 15, register index that holds the PC
- PC_RESET, 0, PC value after reset
- PC_STEP, 4, PC increment per advance
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr  in  NUM_RD*AW  read addresses, port i in slice i
- rd_data  out  NUM_RD*DATA_W  read data, port i in slice i
- rd_pending  out  NUM_RD  port i's register has an outstanding load
- wa_en / wa_addr / wa_data  in  1 / AW / DATA_W  write port A (ALU)
- wb_en / wb_addr / wb_data  in  1 / AW / DATA_W  write port B (load writeback)
- ld_issue / ld_rd  in  1 / AW  load issued; ld_rd will be written later via port B
- pc_en  in  1  advance PC by PC_STEP this cycle
- pc_out  out  DATA_W  current PC (registered)
- sb_err  out  1  one-cycle registered scoreboard-hazard pulse

## Operation
- Reset (rst_n low, immediate): all registers 0, PC = PC_RESET, all pending bits 0, sb_err 0. Reset mid-write discards the write; pending loads are forgotten.
- Reads: combinational from register state. rd_addr == PC_IDX returns the PC register.
- BYPASS=1: if a write port targets the read address in the same cycle, rd_data returns that write data (port B over port A). BYPASS=0: pre-edge state only.
- Writes: on the edge, wa_en writes wa_addr, wb_en writes wb_addr. Same address on both: port B wins, port A dropped.
- PC update, priority order: (1) wb_en && wb_addr==PC_IDX -> wb_data; (2) wa_en && wa_addr==PC_IDX -> wa_data; (3) pc_en -> PC + PC_STEP, modulo 2^DATA_W; (4) hold. A write to PC overrides pc_en in the same cycle.
- Scoreboard: ld_issue sets pending[ld_rd]; wb_en clears pending[wb_addr]. If set and clear hit the same register in one cycle, set wins (the new load is outstanding). rd_pending[i] = pending[rd_addr[i]] from registered state. No bypass: a register written by port B in cycle N reports not-pending from cycle N+1.
- sb_err is asserted the cycle after any of:
  - ld_issue targets an already-pending register without a same-cycle clear.
  - wa_en writes a pending register. The write still occurs and the pending bit is not cleared.
  - wb_en writes a non-pending register. The write still occurs.

## Timing
- Read latency 0 (combinational); write-to-read visibility is same cycle with BYPASS=1, next cycle otherwise.
- pc_out, pending and sb_err change only on clk rising edge or rst_n falling.
- No handshake. Callers must stall decode while any used rd_pending bit is high.

## Structure
- Package reg_file_pkg holds:
  - the address-width helper function
  - default PC_IDX
  - the sb_err cause enum (SB_DUP_LOAD, SB_WAW_ALU, SB_STRAY_WB), used internally and by the bench.
- Sub-module reg_scoreboard: the pending bit vector, set/clear priority and sb_err generation. Ports: clk, rst_n, ld_issue, ld_rd, wa_en, wa_addr, wb_en, wb_addr, pending vector, sb_err.

## Test plan
- Reset release, pc_en=1 for 3 cycles -> pc_out 0, 4, 8, 12; every rd_data = 0 after reset.
- Same cycle: wa writes R3=0x11, wb writes R3=0x22 -> R3 reads 0x22 the same cycle (BYPASS=1) and afterwards.
- pc_en=1 with wa writing R15=0x1000 -> pc_out=0x1000 next cycle, then 0x1004 on the following advance.
- PC=0xFFFFFFFC, pc_en=1 -> pc_out wraps to 0x00000000.
- ld_issue R5 -> rd_pending high for a port reading R5; wb_en R5=0xABCD -> pending low next cycle and data 0xABCD.
- ld_issue R5 with R5 pending -> sb_err pulses one cycle. wb_en R7 with R7 not pending -> sb_err pulses. Assert rst_n low mid-load -> pending cleared immediately.
